wb_rr_arbiter_2m: RTL and testbench
===================================

Name: wb_rr_arbiter_2m

Overview:
- Two-master, one-slave Wishbone (pipelined, stall-based) arbiter in front of a generated register bank, so a CPU bridge and a DMA/host link can share one control slave.
- One transaction per grant; round-robin fairness.
- Latches the winning master's request and holds it on the slave port.
- Watchdog converts a hung slave cycle into an error to the master.

Parameters:
ADDR_W, 4, slave address width (word address)
DATA_W, 32, data width; SEL width = DATA_W/8
TIMEOUT, 15, max cycles from slave acceptance to ack/err before forced error (1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 request
m0_adr_i  in  ADDR_W  master 0 address
m0_sel_i  in  DATA_W/8  master 0 byte select
m0_dat_i  in  DATA_W  master 0 write data
m0_ack_o, m0_err_o, m0_stall_o  out  1 each  master 0 response
m0_dat_o  out  DATA_W  master 0 read data
m1_*  same set as m0_*, master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave request
s_adr_o  out  ADDR_W; s_sel_o  out  DATA_W/8; s_dat_o  out  DATA_W  latched request
s_ack_i, s_err_i, s_stall_i  in  1 each  slave response
s_dat_i  in  DATA_W  slave read data
grant_o  out  2  one-hot current owner (diagnostic)

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values:
  - state IDLE, grant_o=00, last-served=m1 (so m0 wins first), timeout counter 0.
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_sel_o, s_dat_o all 0.
  - mX_ack_o=mX_err_o=0; mX_stall_o=1.
- Request: master X requests when mX_cyc_i & mX_stb_i.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both: grant the master not last served.
  - On grant, register adr/sel/dat/we, set grant_o and last-served, go to ISSUE next cycle.
  - Grant decision takes 1 cycle. Both mX_stall_o stay 1.
- ISSUE:
  - s_cyc_o=1, s_stb_o=1.
  - Granted master's stall_o = s_stall_i (combinational); other master's stall_o=1.
  - When s_stall_i=0: drop s_stb_o next cycle, clear counter, go to WAIT.
- WAIT:
  - s_cyc_o=1, s_stb_o=0; counter increments each cycle.
  - Ack: on s_ack_i or s_err_i, forward combinationally to the granted master (mX_ack_o/mX_err_o, mX_dat_o=s_dat_i), then go to IDLE. s_cyc_o=0 from the next cycle.
  - Timeout: if the counter reaches TIMEOUT with no ack/err, pulse mX_err_o for 1 cycle, drop s_cyc_o, go to IDLE.
  - Ack/err and timeout in the same cycle: the slave response wins; no error is generated.
- Response gating:
  - Ungranted master never sees ack/err.
  - mX_dat_o = s_dat_i when granted, else 0.
  - s_ack_i/s_err_i arriving in IDLE or ISSUE are ignored.
- Master abort: granted master dropping cyc during ISSUE/WAIT does not abort the slave cycle. It completes or times out; its response is still gated to that master (master ignores it).
- Back-to-back: after IDLE re-entry, re-arbitration happens in that same IDLE cycle. Minimum spacing between slave strobes is 3 cycles.
- Fairness: under continuous requests from both masters, grants strictly alternate.
- Reset mid-operation: all state cleared in one cycle regardless of FSM state. In-flight slave cycle is abandoned (s_cyc_o=0), and no ack/err reaches a master.

Test Plan:
- Single m0 write adr=3, dat=0x0000_00F0, sel=F, slave acks 1 cycle after acceptance.
  - Response: s_adr_o=3, s_dat_o=0xF0 registered; m0_ack_o one pulse; m1 sees nothing; grant_o returns to 00.
- m0 and m1 both request continuously for 4 transactions each.
  - Response: grant order m0,m1,m0,m1,...; each master gets exactly 4 acks.
- Slave holds s_stall_i=1 for 3 cycles during ISSUE.
  - Response: s_stb_o held 3+1 cycles; m0_stall_o mirrors s_stall_i; exactly one slave strobe accepted.
- Slave never acks, TIMEOUT=15.
  - Response: m1_err_o pulses exactly 15 cycles after acceptance; s_cyc_o falls next cycle.
  - Then a m0 request is serviced normally.
- Read: slave returns s_dat_i=0xDEAD_BEEF with ack on the counter=TIMEOUT cycle.
  - Response: m0_ack_o=1, m0_dat_o=0xDEADBEEF, m0_err_o=0.
- rst_i asserted for 1 cycle in WAIT.
  - Response: next cycle s_cyc_o=0, grant_o=00, both stall=1, no ack/err.
  - A late s_ack_i is ignored.

Source files
------------

// File: rtl/wb_rr_arbiter_2m.sv
// Two-master, one-slave pipelined Wishbone arbiter with round-robin fairness.
// Each grant carries exactly one transaction: the winner's request is latched
// and presented on the slave port. A watchdog turns a hung slave cycle into an
// error back to the owning master.
module wb_rr_arbiter_2m #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_stall_o,
  output logic [DATA_W-1:0]   m0_dat_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_stall_o,
  output logic [DATA_W-1:0]   m1_dat_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i,
  input  logic [DATA_W-1:0]   s_dat_i,

  output logic [1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Cycles waited are counted from zero, so the limit is hit when count+1
  // equals TIMEOUT; nine bits keep that sum from wrapping at TIMEOUT=255.
  localparam logic [8:0] TIMEOUT_V = 9'(TIMEOUT);

  logic [1:0]        state;
  logic [1:0]        grant;
  logic              last_m1;
  logic [7:0]        wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] dat_q;

  logic req0;
  logic req1;
  logic pick_m1;
  logic slave_done;
  logic timeout_hit;
  logic timeout_err;
  logic in_wait;
  logic issuing;

  // Arbitration and watchdog decode for the current cycle.
  always_comb begin
    req0        = m0_cyc_i & m0_stb_i;
    req1        = m1_cyc_i & m1_stb_i;
    pick_m1     = req1 & (~req0 | ~last_m1);
    slave_done  = s_ack_i | s_err_i;
    timeout_hit = (({1'b0, wait_cnt} + 9'd1) == TIMEOUT_V);
    timeout_err = timeout_hit & ~slave_done;
    in_wait     = (state == ST_WAIT) & ~rst_i;
    issuing     = (state == ST_ISSUE);
  end

  // Transaction sequencing: arbitrate, present the strobe, wait for the reply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      grant    <= 2'b00;
      last_m1  <= 1'b1;
      wait_cnt <= 8'd0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 | req1) begin
            state   <= ST_ISSUE;
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            last_m1 <= pick_m1;
            we_q    <= pick_m1 ? m1_we_i  : m0_we_i;
            adr_q   <= pick_m1 ? m1_adr_i : m0_adr_i;
            sel_q   <= pick_m1 ? m1_sel_i : m0_sel_i;
            dat_q   <= pick_m1 ? m1_dat_i : m0_dat_i;
          end
        end
        ST_ISSUE: begin
          if (!s_stall_i) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        ST_WAIT: begin
          if (slave_done | timeout_hit) begin
            state    <= ST_IDLE;
            grant    <= 2'b00;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Slave port mirrors the latched request while a cycle is open.
  always_comb begin
    s_cyc_o = (state == ST_ISSUE) | (state == ST_WAIT);
    s_stb_o = issuing;
    s_we_o  = we_q;
    s_adr_o = adr_q;
    s_sel_o = sel_q;
    s_dat_o = dat_q;
    grant_o = grant;
  end

  // Responses reach only the owner; replies outside the wait phase are dropped.
  always_comb begin
    m0_stall_o = (issuing & grant[0]) ? s_stall_i : 1'b1;
    m1_stall_o = (issuing & grant[1]) ? s_stall_i : 1'b1;
    m0_ack_o   = in_wait & grant[0] & s_ack_i;
    m1_ack_o   = in_wait & grant[1] & s_ack_i;
    m0_err_o   = in_wait & grant[0] & (s_err_i | timeout_err);
    m1_err_o   = in_wait & grant[1] & (s_err_i | timeout_err);
    m0_dat_o   = grant[0] ? s_dat_i : '0;
    m1_dat_o   = grant[1] ? s_dat_i : '0;
  end

endmodule

// File: tb/tb_wb_rr_arbiter_2m.sv
// Bench for wb_rr_arbiter_2m: a transaction-level model predicts every output
// each cycle, and directed scenarios pin the model with literal expectations.
module tb_wb_rr_arbiter_2m;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = DATA_W / 8;
  localparam int TIMEOUT = 15;

  logic              clk_i;
  logic              rst_i;
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_dat_i;
  logic              m0_ack_o, m0_err_o, m0_stall_o;
  logic [DATA_W-1:0] m0_dat_o;
  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_dat_i;
  logic              m1_ack_o, m1_err_o, m1_stall_o;
  logic [DATA_W-1:0] m1_dat_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [SEL_W-1:0]  s_sel_o;
  logic [DATA_W-1:0] s_dat_o;
  logic              s_ack_i, s_err_i, s_stall_i;
  logic [DATA_W-1:0] s_dat_i;
  logic [1:0]        grant_o;

  wb_rr_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  // Free-running 10 ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int failures  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: owner is -1 when no transaction is open; elapsed counts cycles since
  // the slave accepted the strobe.
  int                m_owner = -1;
  bit                m_acc = 1'b0;
  int                m_elapsed = 0;
  int                m_last = 1;
  logic [ADDR_W-1:0] m_adr = '0;
  logic [SEL_W-1:0]  m_sel = '0;
  logic [DATA_W-1:0] m_dat = '0;
  logic              m_we = 1'b0;
  bit                model_valid = 1'b0;

  function automatic int pickOwner(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  // Advance the model on each rising edge using the inputs present at that edge.
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_owner <= -1; m_acc <= 1'b0; m_elapsed <= 0; m_last <= 1;
      m_adr <= '0; m_sel <= '0; m_dat <= '0; m_we <= 1'b0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      if (m_owner < 0) begin
        if ((m0_cyc_i && m0_stb_i) || (m1_cyc_i && m1_stb_i)) begin
          m_owner <= pickOwner(m0_cyc_i && m0_stb_i, m1_cyc_i && m1_stb_i, m_last);
          m_last  <= pickOwner(m0_cyc_i && m0_stb_i, m1_cyc_i && m1_stb_i, m_last);
          m_acc   <= 1'b0;
          if (pickOwner(m0_cyc_i && m0_stb_i, m1_cyc_i && m1_stb_i, m_last) == 1) begin
            m_adr <= m1_adr_i; m_sel <= m1_sel_i; m_dat <= m1_dat_i; m_we <= m1_we_i;
          end else begin
            m_adr <= m0_adr_i; m_sel <= m0_sel_i; m_dat <= m0_dat_i; m_we <= m0_we_i;
          end
        end
      end else if (!m_acc) begin
        if (!s_stall_i) begin
          m_acc <= 1'b1;
          m_elapsed <= 1;
        end
      end else if (s_ack_i || s_err_i || m_elapsed == TIMEOUT) begin
        m_owner <= -1;
        m_acc <= 1'b0;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk_i) begin
    if (model_valid) begin
      checkOutput("s_cyc_o", s_cyc_o, m_owner >= 0);
      checkOutput("s_stb_o", s_stb_o, m_owner >= 0 && !m_acc);
      checkOutput("s_we_o", s_we_o, m_we);
      checkOutput("s_adr_o", s_adr_o, m_adr);
      checkOutput("s_sel_o", s_sel_o, m_sel);
      checkOutput("s_dat_o", s_dat_o, m_dat);
      checkOutput("grant_o", grant_o, m_owner == 0 ? 2'b01 : (m_owner == 1 ? 2'b10 : 2'b00));
      checkOutput("m0_stall_o", m0_stall_o, (m_owner == 0 && !m_acc) ? s_stall_i : 1'b1);
      checkOutput("m1_stall_o", m1_stall_o, (m_owner == 1 && !m_acc) ? s_stall_i : 1'b1);
      checkOutput("m0_ack_o", m0_ack_o, m_owner == 0 && m_acc && !rst_i && s_ack_i);
      checkOutput("m1_ack_o", m1_ack_o, m_owner == 1 && m_acc && !rst_i && s_ack_i);
      checkOutput("m0_err_o", m0_err_o, m_owner == 0 && m_acc && !rst_i &&
                  (s_err_i || (m_elapsed == TIMEOUT && !s_ack_i)));
      checkOutput("m1_err_o", m1_err_o, m_owner == 1 && m_acc && !rst_i &&
                  (s_err_i || (m_elapsed == TIMEOUT && !s_ack_i)));
      checkOutput("m0_dat_o", m0_dat_o, m_owner == 0 ? s_dat_i : 32'h0);
      checkOutput("m1_dat_o", m1_dat_o, m_owner == 1 ? s_dat_i : 32'h0);
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idleInputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_err_i = 0; s_stall_i = 0; s_dat_i = '0;
  endtask

  // One write from master m, slave acks one cycle after accepting.
  task automatic runSingle(input int m, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    if (m == 0) begin
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = 4'hF;
    end else begin
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = 4'hF;
    end
    tick();
    checkOutput("single grant", grant_o, (m == 0) ? 2'b01 : 2'b10);
    m0_stb_i = 0; m1_stb_i = 0;
    tick();
    s_ack_i = 1;
    settle();
    checkOutput("single ack owner", (m == 0) ? m0_ack_o : m1_ack_o, 1'b1);
    checkOutput("single ack other", (m == 0) ? m1_ack_o : m0_ack_o, 1'b0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m1_cyc_i = 0;
  endtask

  // Random bus activity; ack_pct sets how responsive the slave is.
  task automatic applyStimulus(input int ack_pct);
    m0_cyc_i = ($urandom_range(0, 3) != 0);
    m0_stb_i = 1'($urandom_range(0, 1));
    m0_we_i  = 1'($urandom_range(0, 1));
    m0_adr_i = ADDR_W'($urandom);
    m0_sel_i = SEL_W'($urandom);
    m0_dat_i = $urandom;
    m1_cyc_i = ($urandom_range(0, 3) != 0);
    m1_stb_i = 1'($urandom_range(0, 1));
    m1_we_i  = 1'($urandom_range(0, 1));
    m1_adr_i = ADDR_W'($urandom);
    m1_sel_i = SEL_W'($urandom);
    m1_dat_i = $urandom;
    s_stall_i = ($urandom_range(0, 2) == 0);
    s_ack_i   = ($urandom_range(0, 99) < ack_pct);
    s_err_i   = (ack_pct > 0) && ($urandom_range(0, 19) == 0);
    s_dat_i   = $urandom;
    rst_i     = ($urandom_range(0, 299) == 0);
  endtask

  int n;
  int a0, a1, ngr;
  int order [8];
  int ack_pct;

  // Directed scenarios followed by a randomized soak.
  initial begin
    idleInputs();
    rst_i = 1;
    repeat (2) tick();
    rst_i = 0;
    settle();

    // Reset state.
    checkOutput("reset grant_o", grant_o, 2'b00);
    checkOutput("reset s_cyc_o", s_cyc_o, 1'b0);
    checkOutput("reset m0_stall_o", m0_stall_o, 1'b1);
    checkOutput("reset m1_stall_o", m1_stall_o, 1'b1);
    checkOutput("reset s_adr_o", s_adr_o, 4'h0);

    // Single m0 write, adr 3, data F0.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 4'd3; m0_dat_i = 32'h0000_00F0; m0_sel_i = 4'hF;
    tick();
    checkOutput("write s_adr_o", s_adr_o, 4'd3);
    checkOutput("write s_dat_o", s_dat_o, 32'h0000_00F0);
    checkOutput("write s_stb_o", s_stb_o, 1'b1);
    checkOutput("write grant_o", grant_o, 2'b01);
    m0_stb_i = 0;
    tick();
    s_ack_i = 1;
    settle();
    checkOutput("write m0_ack_o", m0_ack_o, 1'b1);
    checkOutput("write m1_ack_o", m1_ack_o, 1'b0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0;
    settle();
    checkOutput("write m0_ack_o drop", m0_ack_o, 1'b0);
    checkOutput("write grant_o idle", grant_o, 2'b00);

    // Slave stalls the strobe for three cycles.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 4'd5; s_stall_i = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall s_stb_o", s_stb_o, 1'b1);
      checkOutput("stall m0_stall_o", m0_stall_o, 1'b1);
      checkOutput("stall m1_stall_o", m1_stall_o, 1'b1);
      tick();
    end
    s_stall_i = 0;
    settle();
    checkOutput("stall release s_stb_o", s_stb_o, 1'b1);
    checkOutput("stall release m0_stall_o", m0_stall_o, 1'b0);
    m0_stb_i = 0;
    tick();
    checkOutput("stall accepted s_stb_o", s_stb_o, 1'b0);
    checkOutput("stall accepted s_cyc_o", s_cyc_o, 1'b1);
    s_ack_i = 1;
    settle();
    checkOutput("stall m0_ack_o", m0_ack_o, 1'b1);
    tick();
    s_ack_i = 0; m0_cyc_i = 0;

    // Silent slave: m1 must get an error 15 cycles after acceptance.
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 4'd9;
    tick();
    m1_stb_i = 0;
    tick();
    n = 1;
    while (n < 40 && !m1_err_o) begin
      tick();
      n++;
    end
    checkOutput("timeout latency", n, 15);
    checkOutput("timeout m1_err_o", m1_err_o, 1'b1);
    checkOutput("timeout m0_err_o", m0_err_o, 1'b0);
    checkOutput("timeout s_cyc_o", s_cyc_o, 1'b1);
    tick();
    m1_cyc_i = 0;
    settle();
    checkOutput("timeout s_cyc_o drop", s_cyc_o, 1'b0);
    checkOutput("timeout m1_err_o drop", m1_err_o, 1'b0);
    runSingle(0, 4'd2, 32'h1234_5678);

    // Read answered on the last cycle before the watchdog fires.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 4'd7;
    tick();
    m0_stb_i = 0;
    tick();
    repeat (14) tick();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    checkOutput("read m0_ack_o", m0_ack_o, 1'b1);
    checkOutput("read m0_dat_o", m0_dat_o, 32'hDEAD_BEEF);
    checkOutput("read m0_err_o", m0_err_o, 1'b0);
    checkOutput("read m1_dat_o", m1_dat_o, 32'h0);
    tick();
    s_ack_i = 0; s_dat_i = '0; m0_cyc_i = 0;

    // Reset while waiting on the slave, then a late ack.
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 4'd4;
    tick();
    m1_stb_i = 0;
    tick();
    rst_i = 1; s_ack_i = 1; m1_cyc_i = 0;
    settle();
    checkOutput("rst cycle m1_ack_o", m1_ack_o, 1'b0);
    tick();
    rst_i = 0;
    settle();
    checkOutput("post-rst s_cyc_o", s_cyc_o, 1'b0);
    checkOutput("post-rst grant_o", grant_o, 2'b00);
    checkOutput("post-rst m0_stall_o", m0_stall_o, 1'b1);
    checkOutput("post-rst m1_stall_o", m1_stall_o, 1'b1);
    checkOutput("late ack m1_ack_o", m1_ack_o, 1'b0);
    checkOutput("late ack m0_ack_o", m0_ack_o, 1'b0);
    tick();
    s_ack_i = 0;

    // Both masters request continuously: grants must alternate, m0 first.
    for (int k = 0; k < 8; k++) order[k] = -1;
    a0 = 0; a1 = 0; ngr = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_stall_i = 0;
    for (int i = 0; i < 200 && (a0 + a1) < 8; i++) begin
      s_ack_i = s_cyc_o & ~s_stb_o;
      settle();
      if (s_stb_o && ngr < 8) begin
        order[ngr] = (grant_o == 2'b10) ? 1 : ((grant_o == 2'b01) ? 0 : -1);
        ngr++;
      end
      if (m0_ack_o) a0++;
      if (m1_ack_o) a1++;
      if ((a0 + a1) == 8) begin
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      end
      tick();
    end
    s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    for (int k = 0; k < 8; k++) checkOutput("fair order", order[k], k % 2);
    checkOutput("fair m0 acks", a0, 4);
    checkOutput("fair m1 acks", a1, 4);
    tick();

    // Randomized soak with varying slave responsiveness.
    ack_pct = 30;
    for (int c = 0; c < 2000; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 0;
          1:       ack_pct = 30;
          default: ack_pct = 60;
        endcase
      end
      applyStimulus(ack_pct);
      tick();
    end
    idleInputs();
    rst_i = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
